// File: rtl/row_pe.sv
// Row-stationary conv PE: filter/ifmap row scratchpads, 1-D sliding MAC, psum chain.
// Define PE_SATURATE_EN to clamp accumulations instead of two's-complement wrap.
module row_pe #(
  parameter int ROW_IDX      = 0,
  parameter int COL_IDX      = 0,
  parameter int DATA_W       = 8,
  parameter int PSUM_W       = 16,
  parameter int IFMAP_DEPTH  = 16,
  parameter int FILTER_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_in,
  input  logic              change_mode,
  input  logic [DATA_W+8:0] filter_packet,
  input  logic [DATA_W+8:0] ifmap_packet,
  input  logic [1:0]        op_stage_in,
  input  logic [PSUM_W:0]   psum_in,
  input  logic              psum_ack_in,
  input  logic              conv_continue,
  output logic [PSUM_W:0]   psum_out,
  output logic              psum_ack_out,
  output logic              conv_done,
  output logic              error,
  output logic              full
);

  localparam int IAW = $clog2(IFMAP_DEPTH);
  localparam int FAW = $clog2(FILTER_DEPTH);
  localparam int ICW = $clog2(IFMAP_DEPTH + 1);
  localparam int FCW = $clog2(FILTER_DEPTH + 1);
  localparam int CW  = (ICW > FCW ? ICW : FCW) + 2;
  localparam int PW2 = 2 * DATA_W;
  localparam int SW  = (PSUM_W > PW2 ? PSUM_W : PW2) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t r_state, w_nstate;

  logic [1:0]  r_mode;
  logic [ICW-1:0] r_icnt;
  logic [FCW-1:0] r_fcnt;
  logic signed [DATA_W-1:0] r_ifmap [IFMAP_DEPTH];
  logic signed [DATA_W-1:0] r_filter [FILTER_DEPTH];
  logic [2:0]  r_k;
  logic [IAW-1:0] r_base;
  logic signed [PSUM_W-1:0] r_acc;
  logic        r_pvalid;
  logic [PSUM_W-1:0] r_pdata;
  logic        r_ack;
  logic        r_err;

  logic [2:0]  w_k;
  logic [1:0]  w_s;
  logic        w_load;
  logic        w_fhit, w_ihit;
  logic        w_fwr, w_iwr;
  logic        w_ffull;
  logic        w_short;
  logic        w_fit;
  logic        w_err_n;
  logic        w_latch;
  logic        w_clr_i, w_clr_f;
  logic [IAW-1:0] w_iidx;
  logic [FAW-1:0] w_fidx;
  logic signed [PW2-1:0] w_prod;
  logic signed [SW-1:0]  w_acc_x, w_prod_x, w_ps_x;

  function automatic logic [PSUM_W-1:0] f_add(
    input logic signed [SW-1:0] a,
    input logic signed [SW-1:0] b
  );
    logic signed [SW:0] s;
`ifdef PE_SATURATE_EN
    logic signed [SW:0] hi, lo;
    hi = {{(SW+2-PSUM_W){1'b0}}, {(PSUM_W-1){1'b1}}};
    lo = {{(SW+2-PSUM_W){1'b1}}, {(PSUM_W-1){1'b0}}};
`endif
    s = {a[SW-1], a} + {b[SW-1], b};
`ifdef PE_SATURATE_EN
    if (s > hi) return hi[PSUM_W-1:0];
    if (s < lo) return lo[PSUM_W-1:0];
`endif
    return s[PSUM_W-1:0];
  endfunction

  assign w_k = r_mode[0] ? 3'd5 : 3'd3;
  assign w_s = r_mode[1] ? 2'd2 : 2'd1;

  // Scratchpads only fill while the array is loading and we are idle/loading
  assign w_load = (op_stage_in == 2'd1) &&
                  (r_state == S_IDLE || r_state == S_LOAD);

  assign w_fhit = filter_packet[DATA_W+8] && w_load &&
                  filter_packet[DATA_W+7:DATA_W+4] == 4'(ROW_IDX) &&
                  filter_packet[DATA_W+3:DATA_W] == 4'(COL_IDX);
  assign w_ihit = ifmap_packet[DATA_W+8] && w_load &&
                  ifmap_packet[DATA_W+7:DATA_W+4] == 4'(ROW_IDX) &&
                  ifmap_packet[DATA_W+3:DATA_W] == 4'(COL_IDX);

  assign full    = (r_icnt == ICW'(IFMAP_DEPTH));
  assign w_ffull = (r_fcnt == FCW'(FILTER_DEPTH));
  assign w_iwr   = w_ihit && !full;
  assign w_fwr   = w_fhit && !w_ffull;

  assign w_short = (CW'(r_icnt) < CW'(w_k)) || (CW'(r_fcnt) < CW'(w_k));
  assign w_fit   = (CW'(r_base) + CW'(w_s) + CW'(w_k)) <= CW'(r_icnt);

  assign w_iidx   = r_base + IAW'(r_k);
  assign w_fidx   = FAW'(r_k);
  assign w_prod   = r_filter[w_fidx] * r_ifmap[w_iidx];
  assign w_acc_x  = {{(SW-PSUM_W){r_acc[PSUM_W-1]}}, r_acc};
  assign w_prod_x = {{(SW-PW2){w_prod[PW2-1]}}, w_prod};
  assign w_ps_x   = {{(SW-PSUM_W){psum_in[PSUM_W-1]}}, psum_in[PSUM_W-1:0]};

  always_comb begin
    w_nstate = r_state;
    w_err_n  = (w_ihit && full) || (w_fhit && w_ffull);
    w_latch  = 1'b0;
    w_clr_i  = 1'b0;
    w_clr_f  = 1'b0;
    if (change_mode && r_state != S_IDLE && r_state != S_DONE)
      w_err_n = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_latch = change_mode;
        if (op_stage_in == 2'd1) w_nstate = S_LOAD;
      end
      S_LOAD: begin
        if (op_stage_in == 2'd2) begin
          if (w_short) begin
            w_err_n  = 1'b1;
            w_nstate = S_DONE;
          end else begin
            w_nstate = S_MAC;
          end
        end
      end
      S_MAC: begin
        if (r_k == w_k - 3'd1) w_nstate = S_WAIT;
      end
      S_WAIT: begin
        if (psum_in[PSUM_W]) w_nstate = S_OUT;
      end
      S_OUT: begin
        if (psum_ack_in) w_nstate = w_fit ? S_MAC : S_DONE;
      end
      S_DONE: begin
        if (change_mode) begin
          w_latch  = 1'b1;
          w_clr_i  = 1'b1;
          w_clr_f  = 1'b1;
          w_nstate = S_IDLE;
        end else if (conv_continue) begin
          w_clr_i  = 1'b1;
          w_nstate = S_LOAD;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_iwr) r_ifmap[r_icnt[IAW-1:0]] <= ifmap_packet[DATA_W-1:0];
    if (w_fwr) r_filter[r_fcnt[FAW-1:0]] <= filter_packet[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'd0;
      r_icnt   <= '0;
      r_fcnt   <= '0;
      r_k      <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_pvalid <= 1'b0;
      r_pdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_err   <= w_err_n;
      r_ack   <= 1'b0;
      if (w_latch) r_mode <= mode_in;
      if (w_clr_i)    r_icnt <= '0;
      else if (w_iwr) r_icnt <= r_icnt + ICW'(1);
      if (w_clr_f)    r_fcnt <= '0;
      else if (w_fwr) r_fcnt <= r_fcnt + FCW'(1);
      unique case (r_state)
        S_LOAD: begin
          if (w_nstate == S_MAC) begin
            r_k    <= '0;
            r_base <= '0;
            r_acc  <= '0;
          end
        end
        S_MAC: begin
          r_acc <= f_add(w_acc_x, w_prod_x);
          r_k   <= r_k + 3'd1;
        end
        S_WAIT: begin
          if (psum_in[PSUM_W]) begin
            r_pdata  <= f_add(w_acc_x, w_ps_x);
            r_pvalid <= 1'b1;
            r_ack    <= 1'b1;
          end
        end
        S_OUT: begin
          if (psum_ack_in) begin
            r_pvalid <= 1'b0;
            r_k      <= '0;
            r_acc    <= '0;
            r_base   <= r_base + IAW'(w_s);
          end
        end
        default: ;
      endcase
    end
  end

  assign psum_out     = {r_pvalid, r_pdata};
  assign psum_ack_out = r_ack;
  assign error        = r_err;
  assign conv_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_row_pe.sv
// Bench for row_pe: directed cases plus randomized rounds against a window-sum model.
module tb_row_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_in;
  logic        change_mode;
  logic [16:0] filter_packet;
  logic [16:0] ifmap_packet;
  logic [1:0]  op_stage_in;
  logic [16:0] psum_in;
  logic        psum_ack_in;
  logic        conv_continue;
  logic [16:0] psum_out;
  logic        psum_ack_out;
  logic        conv_done;
  logic        error;
  logic        full;

  row_pe dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .change_mode(change_mode),
    .filter_packet(filter_packet), .ifmap_packet(ifmap_packet),
    .op_stage_in(op_stage_in), .psum_in(psum_in), .psum_ack_in(psum_ack_in),
    .conv_continue(conv_continue), .psum_out(psum_out),
    .psum_ack_out(psum_ack_out), .conv_done(conv_done), .error(error),
    .full(full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int fq[$];
  int iq[$];
  int cur_k = 3;
  int cur_s = 1;

  always @(negedge clk) if (error) err_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fit(input longint v);
`ifdef PE_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    longint m;
    m = v & 64'hFFFF;
    if (m >= 32768) m = m - 65536;
    return int'(m);
`endif
  endfunction

  function automatic int model(input int o, input int ps);
    longint acc = 0;
    for (int j = 0; j < cur_k; j++)
      acc = fit(acc + longint'(fq[j]) * iq[o * cur_s + j]);
    return fit(acc + ps);
  endfunction

  task automatic pkt(input bit isf, input bit [3:0] col, input int v);
    bit [7:0] d;
    d = v[7:0];
    @(negedge clk);
    if (isf) filter_packet = {1'b1, 4'd0, col, d};
    else     ifmap_packet  = {1'b1, 4'd0, col, d};
    @(negedge clk);
    filter_packet = '0;
    ifmap_packet  = '0;
  endtask

  task automatic send_f(input int v);
    pkt(1'b1, 4'd0, v);
    if (fq.size() < 8) fq.push_back(v);
  endtask

  task automatic send_i(input int v);
    pkt(1'b0, 4'd0, v);
    if (iq.size() < 16) iq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    fq.delete(); iq.delete();
    cur_k = 3; cur_s = 1;
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    mode_in = 2'(m);
    change_mode = 1'b1;
    @(negedge clk) change_mode = 1'b0;
    cur_k = m[0] ? 5 : 3;
    cur_s = m[1] ? 2 : 1;
    fq.delete(); iq.delete();
  endtask

  task automatic begin_load();
    @(negedge clk) op_stage_in = 2'd1;
    @(negedge clk);
  endtask

  task automatic pulse_continue();
    @(negedge clk) conv_continue = 1'b1;
    @(negedge clk) conv_continue = 1'b0;
    iq.delete();
  endtask

  task automatic run(input bit rnd, input int ps_fix, input int dly);
    int nout, ps, exp, d;
    bit got;
    nout = (iq.size() - cur_k) / cur_s + 1;
    @(negedge clk) op_stage_in = 2'd2;
    @(negedge clk) op_stage_in = 2'd0;
    for (int o = 0; o < nout; o++) begin
      ps  = rnd ? int'($urandom_range(65535)) - 32768 : ps_fix;
      d   = rnd ? int'($urandom_range(dly)) : dly;
      exp = model(o, ps);
      psum_in = {1'b1, 16'(ps)};
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(posedge clk); #1;
        got = psum_ack_out;
      end
      chk("ack_seen", 32'(got), 1);
      if (!got) begin
        psum_in = '0;
        return;
      end
      chk("psum", $signed(psum_out[15:0]), exp);
      chk("valid", 32'(psum_out[16]), 1);
      @(negedge clk) psum_in = '0;
      for (int c = 0; c < d; c++) begin
        @(posedge clk); #1;
        chk("hold", 32'(psum_out), 32'({1'b1, 16'(exp)}));
      end
      @(negedge clk) psum_ack_in = 1'b1;
      @(posedge clk); #1;
      chk("vclr", 32'(psum_out[16]), 0);
      chk("ackpulse", 32'(psum_ack_out), 0);
      @(negedge clk) psum_ack_in = 1'b0;
    end
    chk("done", 32'(conv_done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    rst = 1'b1;
    mode_in = '0; change_mode = 1'b0;
    filter_packet = '0; ifmap_packet = '0;
    op_stage_in = '0; psum_in = '0;
    psum_ack_in = 1'b0; conv_continue = 1'b0;
    @(negedge clk);
    chk("rst_psum", 32'(psum_out), 0);
    chk("rst_ack", 32'(psum_ack_out), 0);
    chk("rst_done", 32'(conv_done), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_full", 32'(full), 0);
    @(negedge clk) rst = 1'b0;

    begin_load();
    for (int v = 1; v <= 3; v++) send_f(v);
    for (int v = 1; v <= 5; v++) send_i(v);
    chk("full_low", 32'(full), 0);
    run(1'b0, 0, 0);

    pulse_continue();
    chk("cont_full", 32'(full), 0);
    chk("cont_done", 32'(conv_done), 0);
    begin_load();
    for (int j = 0; j < 3; j++) send_i(2);
    run(1'b0, 0, 0);

    set_mode(0);
    begin_load();
    for (int v = 1; v <= 3; v++) send_f(v);
    for (int v = 1; v <= 5; v++) send_i(v);
    run(1'b0, 100, 5);

    set_mode(2);
    begin_load();
    for (int j = 0; j < 3; j++) send_f(1);
    for (int v = 1; v <= 7; v++) send_i(v);
    run(1'b0, 0, 1);

    set_mode(0);
    begin_load();
    e0 = err_cnt;
    for (int j = 0; j < 9; j++) send_f(int'($urandom_range(255)) - 128);
    @(negedge clk);
    chk("err_fovf", err_cnt - e0, 1);
    for (int j = 0; j < 16; j++) send_i(int'($urandom_range(255)) - 128);
    chk("full_high", 32'(full), 1);
    send_i(99);
    @(negedge clk);
    chk("err_iovf", err_cnt - e0, 2);
    chk("full_hold", 32'(full), 1);
    pkt(1'b0, 4'd1, 55);
    @(negedge clk);
    chk("err_tag", err_cnt - e0, 2);
    run(1'b1, 0, 2);

    pulse_continue();
    e0 = err_cnt;
    @(negedge clk);
    mode_in = 2'd3;
    change_mode = 1'b1;
    @(negedge clk) change_mode = 1'b0;
    @(negedge clk);
    chk("err_mode", err_cnt - e0, 1);
    begin_load();
    for (int j = 0; j < 6; j++) send_i(int'($urandom_range(255)) - 128);
    run(1'b1, 0, 1);

    pulse_continue();
    begin_load();
    send_i(4); send_i(5);
    e0 = err_cnt;
    @(negedge clk) op_stage_in = 2'd2;
    @(negedge clk) op_stage_in = 2'd0;
    @(negedge clk);
    chk("err_short", err_cnt - e0, 1);
    chk("short_done", 32'(conv_done), 1);

    set_mode(0);
    begin_load();
    for (int v = 1; v <= 3; v++) send_f(v);
    for (int v = 1; v <= 5; v++) send_i(v);
    @(negedge clk) op_stage_in = 2'd2;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_psum", 32'(psum_out), 0);
    chk("mid_done", 32'(conv_done), 0);
    chk("mid_full", 32'(full), 0);
    @(negedge clk);
    rst = 1'b0;
    op_stage_in = 2'd0;
    fq.delete(); iq.delete();
    cur_k = 3; cur_s = 1;

    begin_load();
    for (int j = 0; j < 3; j++) send_f(127);
    for (int j = 0; j < 3; j++) send_i(127);
    run(1'b0, 32767, 0);

    for (int it = 0; it < 25; it++) begin
      int nf, ni;
      do_reset();
      set_mode(int'($urandom_range(3)));
      begin_load();
      nf = int'($urandom_range(8, cur_k));
      ni = int'($urandom_range(16, cur_k));
      for (int j = 0; j < nf; j++) send_f(int'($urandom_range(255)) - 128);
      for (int j = 0; j < ni; j++) send_i(int'($urandom_range(255)) - 128);
      run(1'b1, 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
